alu_multicycle: RTL and testbench

- Parametrised, sequential successor to the single-cycle datapath ALU.
- Adds iterative unsigned multiply and divide alongside ADD/SUB/AND/ORR.
- Wraps all operations in a valid/ready handshake so the multi-cycle control unit can stall on long operations.
- Produces a WIDTH-bit result plus NZCV flags in the same {N,Z,C,V} order the condition-check logic consumes.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_unit.sv | 85 ++++++++
 rtl/alu_multicycle.sv | 133 +++++++++++++
 tb/tb_alu_multicycle.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode encoding,
// control FSM states and NZCV flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_UDIV = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared WIDTH-step iterative datapath: LSB-first shift-add multiply and
// restoring divide, one step per clock while the counter is nonzero.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIV_ENABLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  alu_op_e            op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  // hi_q: product high half / partial remainder; lo_q: multiplier / quotient.
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div_q;

  logic [WIDTH:0]   sum, shifted, diff;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hi_n    = hi_q;
    lo_n    = lo_q;
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // The final step's outcome is offered combinationally so the top level
  // can register it on the same edge the counter reaches zero.
  assign done     = (cnt_q == CW'(1));
  assign result   = {hi_n, lo_n};
  assign overflow = !div_q && (hi_n != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (start) begin
      cnt_q  <= CW'(WIDTH);
      div_q  <= (DIV_ENABLE != 0) && (op == OP_UDIV);
      hi_q   <= '0;
      if ((DIV_ENABLE != 0) && (op == OP_UDIV)) begin
        lo_q   <= a;
        opnd_q <= b;
      end else begin
        lo_q   <= b;
        opnd_q <= a;
      end
    end else if (cnt_q != '0) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic ops, and
// fixed-latency iterative MUL/UDIV; result and {N,Z,C,V} held until taken.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIV_ENABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  state_e  state_q, state_d;
  alu_op_e op_in;
  logic    accept, use_iter;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] single_res;
  logic             single_c, single_v;
  logic [3:0]       single_flags;

  logic               iter_done, iter_ovf;
  logic [2*WIDTH-1:0] iter_result;
  logic [WIDTH-1:0]   iter_res;
  logic [3:0]         iter_flags;
  logic               unused_rem;

  assign op_in    = alu_op_e'(ALUControl);
  assign accept   = in_valid && in_ready;
  // Divide by zero never enters the iteration; it completes like a 1-cycle op.
  assign use_iter = (op_in == OP_MUL) ||
                    ((DIV_ENABLE != 0) && (op_in == OP_UDIV) && (SrcB != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = use_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (iter_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    add_sum    = {1'b0, SrcA} + {1'b0, SrcB};
    sub_sum    = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
    single_res = '0;
    single_c   = 1'b0;
    single_v   = 1'b0;
    case (op_in)
      OP_ADD: begin
        single_res = add_sum[WIDTH-1:0];
        single_c   = add_sum[WIDTH];
        single_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        single_res = sub_sum[WIDTH-1:0];
        single_c   = sub_sum[WIDTH];
        single_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                     (sub_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND: single_res = SrcA & SrcB;
      OP_ORR: single_res = SrcA | SrcB;
      OP_UDIV: single_v  = (DIV_ENABLE != 0);
      default: single_res = '0;
    endcase
    single_flags         = '0;
    single_flags[FLAG_N] = single_res[WIDTH-1];
    single_flags[FLAG_Z] = (single_res == '0);
    single_flags[FLAG_C] = single_c;
    single_flags[FLAG_V] = single_v;
  end

  alu_iter_unit #(
    .WIDTH      (WIDTH),
    .DIV_ENABLE (DIV_ENABLE)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && use_iter),
    .op       (op_in),
    .a        (SrcA),
    .b        (SrcB),
    .done     (iter_done),
    .result   (iter_result),
    .overflow (iter_ovf)
  );

  // The remainder half of a divide is not architecturally visible.
  assign iter_res   = iter_result[WIDTH-1:0];
  assign unused_rem = ^iter_result[2*WIDTH-1:WIDTH];

  always_comb begin
    iter_flags         = '0;
    iter_flags[FLAG_N] = iter_res[WIDTH-1];
    iter_flags[FLAG_Z] = (iter_res == '0);
    iter_flags[FLAG_V] = iter_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= '0;
      ALUFlags  <= '0;
    end else if (accept && !use_iter) begin
      ALUResult <= single_res;
      ALUFlags  <= single_flags;
    end else if ((state_q == S_BUSY) && iter_done) begin
      ALUResult <= iter_res;
      ALUFlags  <= iter_flags;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32), with a second
// instance built with DIV_ENABLE=0.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_valid_nd = 1'b0;
  logic         in_ready, in_ready_nd;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic [2:0]   ALUControl = 3'b000;
  logic         out_valid, out_valid_nd;
  logic         out_ready = 1'b0;
  logic [W-1:0] ALUResult, ALUResult_nd;
  logic [3:0]   ALUFlags, ALUFlags_nd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .DIV_ENABLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .ALUFlags(ALUFlags)
  );

  alu_multicycle #(.WIDTH(W), .DIV_ENABLE(0)) dut_nd (
    .clk(clk), .reset(reset), .in_valid(in_valid_nd), .in_ready(in_ready_nd),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid_nd),
    .out_ready(out_ready), .ALUResult(ALUResult_nd), .ALUFlags(ALUFlags_nd)
  );

  // Presents one op, scrambles inputs after the accept edge, and counts
  // edges (accept edge = 1) until out_valid is seen. Leaves result pending.
  task automatic run_op(input bit nd, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output logic [3:0] fl, output int lat, output bit rdy_seen);
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; out_ready = 1'b0;
    if (nd) in_valid_nd = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_nd = 1'b0;
    SrcA = ~a; SrcB = ~b; ALUControl = 3'b110;
    lat = 1; rdy_seen = 1'b0;
    while (!(nd ? out_valid_nd : out_valid) && lat < 100) begin
      if (nd ? in_ready_nd : in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = nd ? ALUResult_nd : ALUResult;
    fl  = nd ? ALUFlags_nd : ALUFlags;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (ALUResult !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", ALUResult); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", ALUFlags); end
    checks++; if (in_ready_nd !== 1'b1) begin errors++; $display("FAIL reset_nd_in_ready: got %b want 1", in_ready_nd); end
    reset = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [2:0]   op [8] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b011, 3'b110, 3'b111};
    logic [W-1:0] a  [8] = '{32'h1, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h0F000000, 32'd12, 32'hFFFFFFFF};
    logic [W-1:0] b  [8] = '{32'h2, 32'h2, 32'h80000000, 32'h1, 32'h1,
                             32'h000000F0, 32'd34, 32'h1};
    logic [W-1:0] er [8] = '{32'h3, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h0,
                             32'h0F0000F0, 32'h0, 32'h0};
    logic [3:0]   ef [8] = '{4'b0000, 4'b1000, 4'b0110, 4'b1001, 4'b0110,
                             4'b0000, 4'b0100, 4'b0100};
    logic [W-1:0] res; logic [3:0] fl; int lat; bit rs;
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, op[i], a[i], b[i], res, fl, lat, rs);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL single[%0d]_result: got %h want %h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL single[%0d]_flags: got %b want %b", i, fl, ef[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL single[%0d]_latency: got %0d want 1", i, lat); end
      finish_op();
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] a  [4] = '{32'h00010000, 32'd3, 32'h0, 32'hFFFFFFFF};
    logic [W-1:0] b  [4] = '{32'h00010000, 32'd5, 32'h12345678, 32'hFFFFFFFF};
    logic [W-1:0] er [4] = '{32'h0, 32'd15, 32'h0, 32'h00000001};
    logic [3:0]   ef [4] = '{4'b0101, 4'b0000, 4'b0100, 4'b0001};
    logic [W-1:0] res; logic [3:0] fl; int lat; bit rs;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, OP_MUL, a[i], b[i], res, fl, lat, rs);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL mul[%0d]_result: got %h want %h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL mul[%0d]_flags: got %b want %b", i, fl, ef[i]); end
      checks++; if (lat != W + 1) begin errors++; $display("FAIL mul[%0d]_latency: got %0d want %0d", i, lat, W + 1); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul[%0d]_in_ready_busy: got 1 want 0", i); end
      finish_op();
    end
  endtask

  task automatic test_udiv();
    bit           nd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] a  [6] = '{32'd100, 32'd5, 32'hFFFFFFFF, 32'd6, 32'd100, 32'd5};
    logic [W-1:0] b  [6] = '{32'd7, 32'd0, 32'd1, 32'd7, 32'd7, 32'd0};
    logic [W-1:0] er [6] = '{32'h0000000E, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic [3:0]   ef [6] = '{4'b0000, 4'b0101, 4'b1000, 4'b0100, 4'b0100, 4'b0100};
    int           el [6] = '{W + 1, 1, W + 1, W + 1, 1, 1};
    logic [W-1:0] res; logic [3:0] fl; int lat; bit rs;
    for (int i = 0; i < 6; i++) begin
      run_op(nd[i], OP_UDIV, a[i], b[i], res, fl, lat, rs);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL udiv[%0d]_result: got %h want %h", i, res, er[i]); end
      checks++; if (fl !== ef[i]) begin errors++; $display("FAIL udiv[%0d]_flags: got %b want %b", i, fl, ef[i]); end
      checks++; if (lat != el[i]) begin errors++; $display("FAIL udiv[%0d]_latency: got %0d want %0d", i, lat, el[i]); end
      if (nd[i]) begin
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
      end else begin
        finish_op();
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res; logic [3:0] fl; int lat; bit rs;
    run_op(1'b0, OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, res, fl, lat, rs);
    checks++; if (res !== 32'h00F000F0) begin errors++; $display("FAIL bp_result: got %h want 00f000f0", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; ALUControl = OP_ADD; SrcA = 32'd1; SrcB = 32'd1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'h00F000F0 || ALUFlags !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h fl=%b want ov=1 ir=0 res=00f000f0 fl=0000",
                 i, out_valid, in_ready, ALUResult, ALUFlags);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    run_op(1'b0, OP_ORR, 32'h0F000000, 32'h000000F0, res, fl, lat, rs);
    checks++; if (res !== 32'h0F0000F0) begin errors++; $display("FAIL b2b_result: got %h want 0f0000f0", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    finish_op();
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] res; logic [3:0] fl; int lat; bit rs; bit ov_seen;
    @(negedge clk);
    ALUControl = OP_MUL; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== '0 || ALUFlags !== 4'b0000) begin
      errors++;
      $display("FAIL midop_reset: got ir=%b ov=%b res=%h fl=%b want ir=1 ov=0 res=0 fl=0000",
               in_ready, out_valid, ALUResult, ALUFlags);
    end
    @(negedge clk);
    reset = 1'b0;
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    checks++; if (ov_seen) begin errors++; $display("FAIL midop_discard: got out_valid=1 want 0"); end
    run_op(1'b0, OP_ADD, 32'd1, 32'd2, res, fl, lat, rs);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL post_reset_result: got %h want 3", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL post_reset_latency: got %0d want 1", lat); end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_udiv();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
